// File: rtl/nn_grad_accum_if.sv
// Gradient accumulator bus: sample/handshake inputs (i_*) and registered result outputs (o_*).
// The master modport is the stimulus/downstream side and the slave modport is the accumulator.
interface nn_grad_accum_if #(
   parameter int Narg = 16
);
   logic            i_en;
   logic            i_x;
   logic            i_dp;
   logic            i_dn;
   logic            i_ready;
   logic [Narg-1:0] o_arg;
   logic            o_operation;
   logic            o_valid;
   logic            o_overrun;

   modport master (
      output i_en, i_x, i_dp, i_dn, i_ready,
      input  o_arg, o_operation, o_valid, o_overrun
   );

   modport slave (
      input  i_en, i_x, i_dp, i_dn, i_ready,
      output o_arg, o_operation, o_valid, o_overrun
   );
endinterface

// File: rtl/nn_grad_accum.sv
// Windowed stochastic error*activation accumulator; result one cycle after last sample, never stalls (overwrite sets sticky overrun).
// NN_GRAD_CLAMP_EN defined: acc saturates at +/-(2^Narg-1); undefined: acc wraps in Narg+1 bit two's complement.
module nn_grad_accum #(
   parameter int Narg = 16,
   parameter int NWIN = 10
) (
   input  logic           i_clk,
   input  logic           i_rst,
   nn_grad_accum_if.slave bus
);
   localparam int AW = Narg + 1;

   typedef enum logic [0:0] {ACCUM, PEND} state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic signed [AW-1:0]   r_acc;
   logic [NWIN-1:0]        r_cnt;
   logic [Narg-1:0]        r_arg;
   logic                   r_op;
   logic                   r_ovr;

   logic                   w_up;
   logic                   w_down;
   logic                   w_last;
   logic                   w_load;
   logic                   w_set_ovr;
   logic signed [AW:0]     w_ext;
   logic signed [AW-1:0]   w_sum;
   logic [AW-1:0]          w_mag;

   localparam logic signed [AW:0] ONE_EXT = (AW+1)'(1);
   localparam logic signed [AW:0] LIM     = {2'b00, {Narg{1'b1}}};
   localparam logic [NWIN-1:0]    CNT_ONE = NWIN'(1);

   assign w_up   = bus.i_x & bus.i_dp & ~bus.i_dn;
   assign w_down = bus.i_x & bus.i_dn & ~bus.i_dp;
   assign w_last = bus.i_en && (r_cnt == '1);

   // One extra bit so the +/-1 step can be compared against the clamp limit.
   always_comb begin
      w_ext = {r_acc[AW-1], r_acc};
      if (w_up) begin
         w_ext = w_ext + ONE_EXT;
      end else if (w_down) begin
         w_ext = w_ext - ONE_EXT;
      end
`ifdef NN_GRAD_CLAMP_EN
      if ((w_ext > LIM) || (w_ext < -LIM)) begin
         w_sum = r_acc;
      end else begin
         w_sum = w_ext[AW-1:0];
      end
`else
      w_sum = w_ext[AW-1:0];
`endif
      w_mag = w_sum[AW-1] ? -w_sum : w_sum;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_set_ovr   = 1'b0;
      case (r_state)
         ACCUM: begin
            if (w_last) begin
               w_state_nxt = PEND;
               w_load      = 1'b1;
            end
         end
         PEND: begin
            if (w_last) begin
               w_load    = 1'b1;
               w_set_ovr = ~bus.i_ready;
            end else if (bus.i_ready) begin
               w_state_nxt = ACCUM;
            end
         end
         default: w_state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ACCUM;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_arg   <= '0;
         r_op    <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (bus.i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_ONE;
            r_acc <= w_last ? '0 : w_sum;
         end
         if (w_load) begin
            r_arg <= w_mag[Narg-1:0];
            r_op  <= w_sum[AW-1];
         end
         r_ovr <= r_ovr | w_set_ovr;
      end
   end

   assign bus.o_arg       = r_arg;
   assign bus.o_operation = r_op;
   assign bus.o_valid     = (r_state == PEND);
   assign bus.o_overrun   = r_ovr;
endmodule

// File: tb/tb_nn_grad_accum.sv
// Directed bench for nn_grad_accum: a 16-cycle-window instance (Narg=16) and a 64-cycle-window instance (Narg=4).
module tb_nn_grad_accum;
   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   nn_grad_accum_if #(.Narg(16)) bus_a ();
   nn_grad_accum_if #(.Narg(4))  bus_b ();

   nn_grad_accum #(.Narg(16), .NWIN(4)) u_a (.i_clk(clk), .i_rst(rst), .bus(bus_a.slave));
   nn_grad_accum #(.Narg(4),  .NWIN(6)) u_b (.i_clk(clk), .i_rst(rst), .bus(bus_b.slave));

   typedef struct {
      int n_dn;
      int n_up;
      int exp_arg;
      bit exp_op;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Drive one instance for one clock; outputs are sampled 1 time unit after the edge.
   task automatic cyc(input bit sel, input bit en, input bit x, input bit dp, input bit dn, input bit rdy);
      bus_a.i_en = 1'b0; bus_a.i_x = 1'b0; bus_a.i_dp = 1'b0; bus_a.i_dn = 1'b0; bus_a.i_ready = 1'b0;
      bus_b.i_en = 1'b0; bus_b.i_x = 1'b0; bus_b.i_dp = 1'b0; bus_b.i_dn = 1'b0; bus_b.i_ready = 1'b0;
      if (!sel) begin
         bus_a.i_en = en; bus_a.i_x = x; bus_a.i_dp = dp; bus_a.i_dn = dn; bus_a.i_ready = rdy;
      end else begin
         bus_b.i_en = en; bus_b.i_x = x; bus_b.i_dp = dp; bus_b.i_dn = dn; bus_b.i_ready = rdy;
      end
      @(posedge clk);
      #1;
   endtask

   // Sample i of a window: first n_dn decrements, then n_up increments, then zero steps
   // alternating between x=0 and dp=dn=1.
   task automatic sample(input int i, input int n_dn, input int n_up, input bit rdy);
      if (i < n_dn)              cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, rdy);
      else if (i < n_dn + n_up)  cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, rdy);
      else if (i % 2 == 0)       cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, rdy);
      else                       cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, rdy);
   endtask

   task automatic window(input int n_dn, input int n_up, input bit rdy_last, output bit pre_valid);
      for (int i = 0; i < 15; i++) sample(i, n_dn, n_up, 1'b0);
      pre_valid = bus_a.o_valid;
      sample(15, n_dn, n_up, rdy_last);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      rst = 1'b0;
   endtask

   initial begin
      bit pre;
      vecs[0] = '{n_dn: 0,  n_up: 16, exp_arg: 16, exp_op: 1'b0};
      vecs[1] = '{n_dn: 10, n_up: 6,  exp_arg: 4,  exp_op: 1'b1};
      vecs[2] = '{n_dn: 0,  n_up: 0,  exp_arg: 0,  exp_op: 1'b0};
      vecs[3] = '{n_dn: 16, n_up: 0,  exp_arg: 16, exp_op: 1'b1};
      vecs[4] = '{n_dn: 0,  n_up: 3,  exp_arg: 3,  exp_op: 1'b0};
      vecs[5] = '{n_dn: 7,  n_up: 7,  exp_arg: 0,  exp_op: 1'b0};
      vecs[6] = '{n_dn: 9,  n_up: 2,  exp_arg: 7,  exp_op: 1'b1};

      rst = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      chk("rst_valid_a",   int'(bus_a.o_valid),     0);
      chk("rst_arg_a",     int'(bus_a.o_arg),       0);
      chk("rst_op_a",      int'(bus_a.o_operation), 0);
      chk("rst_ovr_a",     int'(bus_a.o_overrun),   0);
      chk("rst_valid_b",   int'(bus_b.o_valid),     0);
      chk("rst_arg_b",     int'(bus_b.o_arg),       0);

      for (int v = 0; v < 7; v++) begin
         window(vecs[v].n_dn, vecs[v].n_up, 1'b0, pre);
         chk($sformatf("v%0d_pre_valid", v), int'(pre), 0);
         chk($sformatf("v%0d_valid", v), int'(bus_a.o_valid), 1);
         chk($sformatf("v%0d_arg", v), int'(bus_a.o_arg), vecs[v].exp_arg);
         chk($sformatf("v%0d_op", v), int'(bus_a.o_operation), int'(vecs[v].exp_op));
         for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
         chk($sformatf("v%0d_hold_valid", v), int'(bus_a.o_valid), 1);
         chk($sformatf("v%0d_hold_arg", v), int'(bus_a.o_arg), vecs[v].exp_arg);
         chk($sformatf("v%0d_hold_op", v), int'(bus_a.o_operation), int'(vecs[v].exp_op));
         cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
         chk($sformatf("v%0d_valid_drop", v), int'(bus_a.o_valid), 0);
      end
      chk("no_ovr_after_vectors", int'(bus_a.o_overrun), 0);

      // Two windows with no consumption: second result overwrites the first.
      window(0, 16, 1'b0, pre);
      window(0, 3, 1'b0, pre);
      chk("ovr_pre_valid", int'(pre), 1);
      chk("ovr_valid", int'(bus_a.o_valid), 1);
      chk("ovr_arg", int'(bus_a.o_arg), 3);
      chk("ovr_flag", int'(bus_a.o_overrun), 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("ovr_sticky", int'(bus_a.o_overrun), 1);

      // Reset clears the sticky flag; then READY on the second completion edge avoids overrun.
      window(0, 16, 1'b0, pre);
      do_reset();
      chk("rst_drop_valid", int'(bus_a.o_valid), 0);
      chk("rst_clr_ovr", int'(bus_a.o_overrun), 0);
      window(0, 16, 1'b0, pre);
      window(0, 3, 1'b1, pre);
      chk("cons_valid", int'(bus_a.o_valid), 1);
      chk("cons_arg", int'(bus_a.o_arg), 3);
      chk("cons_ovr", int'(bus_a.o_overrun), 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("cons_valid_drop", int'(bus_a.o_valid), 0);

      // Partial window discarded by reset, then 16 decrements with EN toggling.
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 15; i++) begin
         cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
         cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      end
      chk("tog_pre_valid", int'(bus_a.o_valid), 0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("tog_valid", int'(bus_a.o_valid), 1);
      chk("tog_arg", int'(bus_a.o_arg), 16);
      chk("tog_op", int'(bus_a.o_operation), 1);

      // Narg=4, 64-cycle window of +1 steps: saturates or wraps depending on build.
      for (int i = 0; i < 63; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("b_pre_valid", int'(bus_b.o_valid), 0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("b_valid", int'(bus_b.o_valid), 1);
`ifdef NN_GRAD_CLAMP_EN
      chk("b_arg", int'(bus_b.o_arg), 15);
`else
      chk("b_arg", int'(bus_b.o_arg), 0);
`endif
      chk("b_op", int'(bus_b.o_operation), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/nn_grad_accum.md
# nn_grad_accum

- Gradient accumulator directly upstream of the weight/bias add/subtract stage.
- Integrates stochastic-bitstream error × activation products over a fixed window of 2^NWIN enabled cycles.
- At the end of each window, presents a magnitude (`arg`) and a direction (`OPERATION`) with a valid/ready handshake; the downstream stage scales `arg` by its rate and applies it to the stored weight.
- Accumulation never pauses for the handshake: the next window starts immediately while the previous result is pending.

## Interface
- `Narg`, 16: width of the `arg` magnitude output. The accumulator is Narg+1 bits, two's complement.
- `NWIN`, 10: log2 of window length in enabled cycles.
- `CLK` in 1: clock, rising edge.
- `RESET` in 1: one clock; reset is synchronous and active-high.
- `EN` in 1: sample enable. When 0, the accumulator and window counter hold.
- `x` in 1: activation stochastic bit.
- `dp` in 1: positive-error stochastic bit.
- `dn` in 1: negative-error stochastic bit.
- `READY` in 1: downstream accepts the result.
- `arg` out Narg: gradient magnitude, registered.
- `OPERATION` out 1: 0 = add, 1 = subtract, registered.
- `VALID` out 1: result pending.
- `OVERRUN` out 1: sticky flag; an unconsumed result was overwritten.

## Operation
- Per enabled cycle, the step is:
  - +1 if x & dp & ~dn
  - −1 if x & dn & ~dp
  - 0 otherwise (x=0, or dp=dn)
- Window counter (NWIN bits) increments on each enabled cycle. The last sample is the cycle where EN=1 and counter = 2^NWIN−1.
- On the last sample:
  - Final sum S = acc + step.
  - Output register loads `arg` = |S| truncated to Narg bits.
  - `OPERATION` = 1 if S<0, else 0; S=0 gives `arg`=0, `OPERATION`=0.
  - `acc` and counter clear to 0 on the same edge.
- FSM states:
  - ACCUM: VALID=0. Window complete → PEND.
  - PEND: VALID=1.
    - VALID & READY without window complete → ACCUM.
    - Window complete & READY=1: old result consumed, new result loaded, stay PEND, no overrun.
    - Window complete & READY=0: new result overwrites, `OVERRUN`←1, stay PEND.
- `arg`/`OPERATION` are stable while VALID=1 and no overwrite occurs.
- `READY` is ignored in ACCUM.
- `OVERRUN` clears only on `RESET`.
- Arithmetic: `acc` is signed Narg+1 bits. Overflow handling is set by the configuration macro (see Configuration).

## Timing
- Latency: result visible on outputs the cycle after the last-sample edge. VALID rises at the same time.
- Handshake completes on an edge where VALID=1 and READY=1. VALID falls the next cycle unless a new window completes on that edge.
- Throughput: one result per 2^NWIN enabled cycles; zero dead cycles between windows.
- Reset values: `arg`=0, `OPERATION`=0, `VALID`=0, `OVERRUN`=0, `acc`=0, counter=0, state ACCUM.
- RESET mid-window discards the partial sum and any pending result. RESET has priority over EN and READY on the same edge.
- EN=0 on what would be the last cycle: no completion; the window ends on the next enabled cycle.

## Configuration
- `NN_GRAD_CLAMP_EN` defined: `acc` saturates at +(2^Narg−1) and −(2^Narg−1). Steps beyond the limit are dropped, so the magnitude never exceeds 2^Narg−1.
- `NN_GRAD_CLAMP_EN` undefined: `acc` wraps modulo 2^(Narg+1) in two's complement. This is safe only when NWIN < Narg.

## Test plan
- NWIN=4, Narg=16; x=1, dp=1, dn=0 for 16 EN cycles, READY=0 → cycle 17: VALID=1, arg=16, OPERATION=0. Hold READY=0 → outputs stable. Pulse READY → VALID=0 next cycle.
- NWIN=4; x=1; 10 cycles dn=1, then 6 cycles dp=1 → arg=4, OPERATION=1.
- NWIN=4; mix of x=0 and dp=dn=1 cycles for a whole window → VALID=1, arg=0, OPERATION=0.
- NWIN=4; READY=0 across two full windows (+16 then +3) → arg=3, OVERRUN=1. Repeat after RESET with READY=1 on the second completion edge → arg=3, OVERRUN=0, VALID stays 1.
- NWIN=6, Narg=4; 64 consecutive +1 steps:
  - with `NN_GRAD_CLAMP_EN` → arg=15, OPERATION=0
  - without → arg=0, OPERATION=0 (wrap)
- NWIN=4; 5 increments, then RESET for 1 cycle, then 16 decrements with EN toggling 1/0 → result only after the 16th enabled cycle: arg=16, OPERATION=1.
